mem_responder: RTL and testbench

Memory-side responder for the fetch/execute memory handshake. It accepts requests on `mem_EN`/`mem_RW` with the address from MAR and write data from MDR. It performs the read or write against an internal word array after a fixed access latency, then raises `MFC`. `MFC` stays high until the initiator drops `mem_EN`. The block sits between the MAR/MDR datapath and main memory, and is the counterpart of the instruction-fetch and execute controllers.

---
 rtl/mem_responder_pkg.sv | 19 +
 rtl/mem_responder_mem_array.sv | 40 ++++
 rtl/mem_responder.sv | 114 +++++++++++
 tb/tb_mem_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder and its word array.
package mem_responder_pkg;

  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_WAIT_CYCLES = 2;
  localparam int unsigned CNT_W           = 4;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous word array with registered read data.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is never reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register only moves on a read strobe, so writes leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: handshake FSM, wait counter and request latches
// in front of a synchronous word array.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_EN,
  input  logic              mem_RW,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [DATA_W-1:0] rdata_out,
  output logic              MFC,
  output logic              busy
);

  // Counter is 4 bits wide; WAIT_CYCLES is expected in 0..15.
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mfc_q;
  logic              busy_q;

  logic acc_fire_c;
  logic arr_we_c;
  logic arr_re_c;

  // The array access happens on the ACCESS->DONE edge; an abort suppresses it.
  assign acc_fire_c = (state_q == ST_ACCESS) && mem_EN && (cnt_q == '0);
  assign arr_we_c   = acc_fire_c && (cmd_q == MEM_WRITE);
  assign arr_re_c   = acc_fire_c && (cmd_q == MEM_READ);

  // Handshake FSM with registered MFC/busy so both come straight off flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= MEM_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      mfc_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_EN) begin
            state_q <= ST_SETUP;
            busy_q  <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (mem_EN) begin
            state_q <= ST_ACCESS;
            cmd_q   <= mem_RW;
            addr_q  <= addr_in;
            wdata_q <= wdata_in;
            cnt_q   <= WAIT_INIT;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (!mem_EN) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= ST_DONE;
            mfc_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!mem_EN) begin
            state_q <= ST_IDLE;
            mfc_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          mfc_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (arr_we_c),
    .re_i    (arr_re_c),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata_out)
  );

  assign MFC  = mfc_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a transaction-level memory model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] en_v;
  logic          rw_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic [NI-1:0] mfc_v;
  logic [NI-1:0] busy_v;
  logic [DW-1:0] rd0, rd1, rd2;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: per-instance memory image, known-valid flags and expected read data.
  logic [DW-1:0] mdl_mem [NI][256];
  bit            mdl_vld [NI][256];
  logic [DW-1:0] mdl_rd  [NI];
  bit            mdl_rd_known [NI];

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .mem_EN(en_v[0]), .mem_RW(rw_i), .addr_in(addr_i),
    .wdata_in(wdata_i), .rdata_out(rd0), .MFC(mfc_v[0]), .busy(busy_v[0]));
  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n), .mem_EN(en_v[1]), .mem_RW(rw_i), .addr_in(addr_i),
    .wdata_in(wdata_i), .rdata_out(rd1), .MFC(mfc_v[1]), .busy(busy_v[1]));
  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(5)) u_dut_w5 (
    .clk(clk), .rst_n(rst_n), .mem_EN(en_v[2]), .mem_RW(rw_i), .addr_in(addr_i),
    .wdata_in(wdata_i), .rdata_out(rd2), .MFC(mfc_v[2]), .busy(busy_v[2]));

  function automatic int wait_of(input int idx);
    case (idx)
      0:       return 2;
      1:       return 0;
      default: return 5;
    endcase
  endfunction

  function automatic logic [DW-1:0] cur_rd(input int idx);
    case (idx)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic scramble();
    rw_i    = 1'($urandom);
    addr_i  = AW'($urandom);
    wdata_i = DW'($urandom);
  endtask

  // One transaction; abort_at=n drops mem_EN after the n-th edge from E0 (0 = no abort).
  // Called #1 after an edge with the DUT idle; returns #1 after the edge that re-enters IDLE.
  task automatic run_txn(input int idx, input logic rw, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int hold, input int abort_at);
    int w;
    logic [DW-1:0] rd_before;
    w = wait_of(idx);
    rd_before = cur_rd(idx);
    scramble();
    rw_i = ~rw;
    en_v[idx] = 1'b1;
    for (int n = 1; n <= w + 3; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        chk_eq("busy_from_e0", 32'(busy_v[idx]), 32'd1);
        rw_i = rw; addr_i = a; wdata_i = d;
      end else if (n == 2) begin
        scramble();
      end
      if (n < w + 3) chk_eq("mfc_early", 32'(mfc_v[idx]), 32'd0);
      if (abort_at == n) begin
        en_v[idx] = 1'b0;
        @(posedge clk); #1;
        chk_eq("abort_mfc", 32'(mfc_v[idx]), 32'd0);
        chk_eq("abort_busy", 32'(busy_v[idx]), 32'd0);
        chk_eq("abort_rdata", 32'(cur_rd(idx)), 32'(rd_before));
        return;
      end
    end
    chk_eq("mfc_latency", 32'(mfc_v[idx]), 32'd1);
    chk_eq("busy_done", 32'(busy_v[idx]), 32'd1);
    if (rw == MEM_WRITE) begin
      mdl_mem[idx][a] = d;
      mdl_vld[idx][a] = 1'b1;
    end else if (mdl_vld[idx][a]) begin
      mdl_rd[idx] = mdl_mem[idx][a];
      mdl_rd_known[idx] = 1'b1;
    end else begin
      mdl_rd_known[idx] = 1'b0;
    end
    if (mdl_rd_known[idx]) chk_eq("rdata", 32'(cur_rd(idx)), 32'(mdl_rd[idx]));
    for (int h = 0; h < hold; h++) begin
      scramble();
      @(posedge clk); #1;
      chk_eq("mfc_hold", 32'(mfc_v[idx]), 32'd1);
      if (mdl_rd_known[idx]) chk_eq("rdata_hold", 32'(cur_rd(idx)), 32'(mdl_rd[idx]));
    end
    en_v[idx] = 1'b0;
    @(posedge clk); #1;
    chk_eq("mfc_fall", 32'(mfc_v[idx]), 32'd0);
    chk_eq("busy_fall", 32'(busy_v[idx]), 32'd0);
  endtask

  // Reset pulse while instance 0 sits in ACCESS on a write; the write must vanish.
  task automatic reset_mid_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    rw_i = MEM_WRITE; addr_i = a; wdata_i = d;
    en_v[0] = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk_eq("busy_pre_rst", 32'(busy_v[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_eq("rst_async_mfc", 32'(mfc_v[0]), 32'd0);
    chk_eq("rst_async_busy", 32'(busy_v[0]), 32'd0);
    chk_eq("rst_rdata", 32'(rd0), 32'd0);
    en_v = '0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < int'(NI); i++) begin
      mdl_rd[i] = '0;
      mdl_rd_known[i] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int idx;
    int w;
    en_v = '0; rw_i = 1'b0; addr_i = '0; wdata_i = '0;
    for (int i = 0; i < int'(NI); i++) begin
      mdl_rd[i] = '0;
      mdl_rd_known[i] = 1'b1;
      for (int j = 0; j < 256; j++) mdl_vld[i][j] = 1'b0;
    end
    repeat (3) @(posedge clk); #1;
    chk_eq("rst_mfc", 32'(mfc_v), 32'd0);
    chk_eq("rst_busy", 32'(busy_v), 32'd0);
    chk_eq("rst_rd0", 32'(rd0), 32'd0);
    chk_eq("rst_rd1", 32'(rd1), 32'd0);
    chk_eq("rst_rd2", 32'(rd2), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: write/read, preload, abort, hold, back-to-back.
    run_txn(0, MEM_WRITE, 8'h10, 16'hBEEF, 0, 0);
    run_txn(0, MEM_READ,  8'h10, 16'h0000, 0, 0);
    run_txn(0, MEM_WRITE, 8'h01, 16'h0001, 0, 0);
    run_txn(0, MEM_WRITE, 8'h02, 16'h0002, 0, 0);
    run_txn(0, MEM_WRITE, 8'h03, 16'h0003, 0, 0);
    run_txn(0, MEM_WRITE, 8'h20, 16'h5A5A, 0, 0);
    run_txn(0, MEM_WRITE, 8'h20, 16'h1234, 0, 3);
    run_txn(0, MEM_READ,  8'h20, 16'h0000, 0, 0);
    run_txn(0, MEM_READ,  8'h10, 16'h0000, 10, 0);
    run_txn(0, MEM_WRITE, 8'h30, 16'h7777, 10, 0);
    run_txn(0, MEM_READ,  8'h30, 16'h0000, 0, 0);
    run_txn(0, MEM_READ,  8'h01, 16'h0000, 0, 0);
    run_txn(0, MEM_READ,  8'h02, 16'h0000, 0, 0);
    run_txn(0, MEM_READ,  8'h03, 16'h0000, 0, 0);

    // Latency sweep on the WAIT_CYCLES=0 and 5 instances.
    run_txn(1, MEM_WRITE, 8'h44, 16'hA0A0, 0, 0);
    run_txn(1, MEM_READ,  8'h44, 16'h0000, 2, 0);
    run_txn(2, MEM_WRITE, 8'h44, 16'hC3C3, 0, 0);
    run_txn(2, MEM_READ,  8'h44, 16'h0000, 2, 0);
    run_txn(2, MEM_WRITE, 8'h44, 16'hFFFF, 0, 6);
    run_txn(2, MEM_READ,  8'h44, 16'h0000, 0, 0);

    // Reset mid-access, then the array must still hold the old values.
    reset_mid_write(8'h20, 16'hDEAD);
    run_txn(0, MEM_READ, 8'h20, 16'h0000, 0, 0);
    run_txn(0, MEM_READ, 8'h10, 16'h0000, 0, 0);
    run_txn(2, MEM_READ, 8'h44, 16'h0000, 0, 0);

    // Random mix across all three instances.
    for (int t = 0; t < 80; t++) begin
      idx = (t % 4 == 3) ? int'($urandom_range(1, 2)) : 0;
      w = wait_of(idx);
      run_txn(idx, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom),
              int'($urandom_range(0, 3)),
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, w + 2)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
